dsp_mac_pipe: RTL and testbench



---
 rtl/dsp_mac_pipe.sv | 149 ++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Signed pre-add / multiply / accumulate pipeline with a valid/ready handshake.
// Mode bits travel with each operation; the accumulator saturates or wraps depending on SAT.
module dsp_mac_pipe #(
   parameter int AW      = 18,
   parameter int BW      = 18,
   parameter int PW      = 48,
   parameter int MSTAGES = 2,
   parameter int SAT     = 1
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic signed [AW-1:0] A,
   input  logic signed [BW-1:0] B,
   input  logic signed [BW-1:0] D,
   input  logic signed [PW-1:0] C,
   input  logic [3:0]           OP,
   input  logic                 CLR_OVF,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic signed [PW-1:0] P,
   output logic                 SAT_HIT,
   output logic                 OVF
);

   localparam int MW        = AW + BW + 1;
   localparam int OP_SUB    = 3;
   localparam int OP_ACC    = 2;
   localparam int OP_PRESUB = 1;
   localparam int OP_PREADD = 0;
   localparam bit SAT_EN    = (SAT != 0);

   function automatic logic signed [PW-1:0] sat_clamp(input logic neg);
      if (neg) return {1'b1, {(PW-1){1'b0}}};
      else     return {1'b0, {(PW-1){1'b1}}};
   endfunction

   logic en;
   logic accept;

   logic                 vld_p0;
   logic signed [AW-1:0] a_p0;
   logic signed [BW-1:0] b_p0;
   logic signed [BW-1:0] d_p0;
   logic signed [PW-1:0] c_p0;
   logic [3:0]           op_p0;
   logic signed [BW:0]   bp_p0;
   logic signed [MW-1:0] m_p0;

   logic                 vld_p1 [MSTAGES];
   logic signed [MW-1:0] m_p1   [MSTAGES];
   logic signed [PW-1:0] c_p1   [MSTAGES];
   logic [1:0]           op_p1  [MSTAGES];

   logic signed [PW-1:0] base_p2;
   logic signed [PW:0]   r_p2;
   logic                 ovf_p2;
   logic signed [PW-1:0] p_nxt_p2;

   // The whole pipe advances together so back-pressure never drops or duplicates a token.
   assign en       = !OUT_VALID || OUT_READY;
   assign IN_READY = en;
   assign accept   = IN_VALID && en;

   // ---- stage 0: input capture ----
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)   vld_p0 <= 1'b0;
      else if (en) vld_p0 <= IN_VALID;
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         a_p0  <= A;
         b_p0  <= B;
         d_p0  <= D;
         c_p0  <= C;
         op_p0 <= OP;
      end
   end

   always_comb begin
      bp_p0 = {b_p0[BW-1], b_p0};
      if (op_p0[OP_PREADD]) begin
         if (op_p0[OP_PRESUB]) bp_p0 = {d_p0[BW-1], d_p0} - {b_p0[BW-1], b_p0};
         else                  bp_p0 = {d_p0[BW-1], d_p0} + {b_p0[BW-1], b_p0};
      end
   end

   // Both operands widened to the product width; the low MW bits of the product are exact.
   assign m_p0 = {{(BW+1){a_p0[AW-1]}}, a_p0} * {{AW{bp_p0[BW]}}, bp_p0};

   // ---- stage 1..MSTAGES: multiplier pipeline ----
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < MSTAGES; i++) vld_p1[i] <= 1'b0;
      end else if (en) begin
         vld_p1[0] <= vld_p0;
         for (int i = 1; i < MSTAGES; i++) vld_p1[i] <= vld_p1[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (en) begin
         m_p1[0]  <= m_p0;
         c_p1[0]  <= c_p0;
         op_p1[0] <= {op_p0[OP_SUB], op_p0[OP_ACC]};
         for (int i = 1; i < MSTAGES; i++) begin
            m_p1[i]  <= m_p1[i-1];
            c_p1[i]  <= c_p1[i-1];
            op_p1[i] <= op_p1[i-1];
         end
      end
   end

   // ---- accumulate stage: P register ----
   always_comb begin
      base_p2 = op_p1[MSTAGES-1][0] ? P : c_p1[MSTAGES-1];
      if (op_p1[MSTAGES-1][1])
         r_p2 = {base_p2[PW-1], base_p2}
              - {{(PW+1-MW){m_p1[MSTAGES-1][MW-1]}}, m_p1[MSTAGES-1]};
      else
         r_p2 = {base_p2[PW-1], base_p2}
              + {{(PW+1-MW){m_p1[MSTAGES-1][MW-1]}}, m_p1[MSTAGES-1]};
      ovf_p2   = r_p2[PW] ^ r_p2[PW-1];
      p_nxt_p2 = (ovf_p2 && SAT_EN) ? sat_clamp(r_p2[PW]) : r_p2[PW-1:0];
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         P         <= '0;
         SAT_HIT   <= 1'b0;
         OUT_VALID <= 1'b0;
         OVF       <= 1'b0;
      end else begin
         if (en) begin
            OUT_VALID <= vld_p1[MSTAGES-1];
            if (vld_p1[MSTAGES-1]) begin
               P       <= p_nxt_p2;
               SAT_HIT <= ovf_p2 && SAT_EN;
            end
         end
         // A fresh overflow outranks a simultaneous clear.
         if (en && vld_p1[MSTAGES-1] && ovf_p2) OVF <= 1'b1;
         else if (CLR_OVF)                       OVF <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: one saturating and one wrapping instance share stimulus.
module tb_dsp_mac_pipe;

   localparam int AW = 18;
   localparam int BW = 18;
   localparam int PW = 48;

   logic                 CLK = 1'b0;
   logic                 RSTN;
   logic                 IN_VALID;
   logic                 OUT_READY;
   logic                 CLR_OVF;
   logic signed [AW-1:0] A;
   logic signed [BW-1:0] B;
   logic signed [BW-1:0] D;
   logic signed [PW-1:0] C;
   logic [3:0]           OP;

   logic                 IN_READY, OUT_VALID, SAT_HIT, OVF;
   logic signed [PW-1:0] P;
   logic                 in_ready_w, out_valid_w, sat_hit_w, ovf_w;
   logic signed [PW-1:0] p_w;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .MSTAGES(2), .SAT(1)) dut (
      .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .A(A), .B(B), .D(D), .C(C), .OP(OP), .CLR_OVF(CLR_OVF),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .P(P),
      .SAT_HIT(SAT_HIT), .OVF(OVF)
   );

   dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .MSTAGES(2), .SAT(0)) dut_w (
      .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(in_ready_w),
      .A(A), .B(B), .D(D), .C(C), .OP(OP), .CLR_OVF(CLR_OVF),
      .OUT_VALID(out_valid_w), .OUT_READY(OUT_READY), .P(p_w),
      .SAT_HIT(sat_hit_w), .OVF(ovf_w)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                        input logic signed [BW-1:0] d, input logic signed [PW-1:0] c,
                        input logic [3:0] op);
      IN_VALID = 1'b1;
      A  = a;
      B  = b;
      D  = d;
      C  = c;
      OP = op;
   endtask

   task automatic send(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                       input logic signed [BW-1:0] d, input logic signed [PW-1:0] c,
                       input logic [3:0] op);
      drive(a, b, d, c, op);
      tick();
      IN_VALID = 1'b0;
   endtask

   task automatic test_reset();
      RSTN = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; CLR_OVF = 1'b0;
      A = '0; B = '0; D = '0; C = '0; OP = '0;
      #12;
      checks++;
      if (P !== 48'sd0) begin errors++; $display("FAIL reset_p: got %0d want 0", P); end
      checks++;
      if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
      checks++;
      if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
      checks++;
      if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", OVF); end
      @(negedge CLK);
      RSTN = 1'b1;
      OUT_READY = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      send(18'sd3, 18'sd4, 18'sd10, 48'sd5, 4'b0011);
      tick();
      tick();
      checks++;
      if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid %b want 0", OUT_VALID); end
      tick();
      checks++;
      if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL latency_valid: out_valid %b want 1", OUT_VALID); end
      checks++;
      if (P !== 48'sd23) begin errors++; $display("FAIL latency_presub_p: got %0d want 23", P); end
      tick();
      checks++;
      if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL latency_one_shot: out_valid %b want 0", OUT_VALID); end
   endtask

   task automatic test_acc_stream();
      logic signed [PW-1:0] exp_p [5];
      exp_p[0] = -48'sd14; exp_p[1] = -48'sd28; exp_p[2] = -48'sd42;
      exp_p[3] = -48'sd56; exp_p[4] = -48'sd70;
      for (int t = 0; t < 8; t++) begin
         if (t == 0)     drive(-18'sd2, 18'sd7, 18'sd0, 48'sd0, 4'b0000);
         else if (t < 5) drive(-18'sd2, 18'sd7, 18'sd0, 48'sd999, 4'b0100);
         else            IN_VALID = 1'b0;
         tick();
         if (t >= 3) begin
            checks++;
            if (OUT_VALID !== 1'b1 || P !== exp_p[t-3]) begin
               errors++;
               $display("FAIL acc_stream[%0d]: got valid=%b p=%0d want valid=1 p=%0d",
                        t-3, OUT_VALID, P, exp_p[t-3]);
            end
         end
      end
      IN_VALID = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      // (2^47-10) + 25 clamps to 2^47-1, or wraps to -2^47+15.
      send(18'sd5, 18'sd5, 18'sd0, 48'sh7FFF_FFFF_FFF6, 4'b0000);
      tick(); tick(); tick();
      checks++;
      if (P !== 48'sh7FFF_FFFF_FFFF) begin errors++; $display("FAIL sat_pos_p: got %0h want 7fffffffffff", P); end
      checks++;
      if (SAT_HIT !== 1'b1 || OVF !== 1'b1) begin
         errors++; $display("FAIL sat_pos_flags: sat_hit=%b ovf=%b want 1 1", SAT_HIT, OVF);
      end
      checks++;
      if (p_w !== 48'sh8000_0000_000F) begin errors++; $display("FAIL wrap_pos_p: got %0h want 80000000000f", p_w); end
      checks++;
      if (sat_hit_w !== 1'b0 || ovf_w !== 1'b1) begin
         errors++; $display("FAIL wrap_pos_flags: sat_hit=%b ovf=%b want 0 1", sat_hit_w, ovf_w);
      end
      CLR_OVF = 1'b1;
      tick();
      CLR_OVF = 1'b0;
      checks++;
      if (OVF !== 1'b0 || ovf_w !== 1'b0) begin
         errors++; $display("FAIL clr_ovf: ovf=%b ovf_w=%b want 0 0", OVF, ovf_w);
      end
      // (-2^47+5) - 25 clamps to -2^47, or wraps to 2^47-20.
      send(18'sd5, 18'sd5, 18'sd0, 48'sh8000_0000_0005, 4'b1000);
      tick(); tick(); tick();
      checks++;
      if (P !== 48'sh8000_0000_0000 || SAT_HIT !== 1'b1) begin
         errors++; $display("FAIL sat_neg: got p=%0h sat_hit=%b want 800000000000 1", P, SAT_HIT);
      end
      checks++;
      if (p_w !== 48'sh7FFF_FFFF_FFEC) begin errors++; $display("FAIL wrap_neg_p: got %0h want 7fffffffffec", p_w); end
      CLR_OVF = 1'b1;
      tick();
      CLR_OVF = 1'b0;
      send(18'sd5, 18'sd5, 18'sd0, 48'sh7FFF_FFFF_FFF6, 4'b0000);
      tick(); tick();
      CLR_OVF = 1'b1;
      tick();
      CLR_OVF = 1'b0;
      checks++;
      if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clear: got %b want 1", OVF); end
      tick();
   endtask

   task automatic test_back_to_back();
      int idx = 0;
      int rcv = 0;
      logic acc;
      for (int cyc = 0; cyc < 40; cyc++) begin
         OUT_READY = !(cyc >= 5 && cyc <= 9);
         if (idx < 6) drive(18'sd1, 18'(idx + 1), 18'sd0, 48'(100 * (idx + 1)), 4'b0000);
         else         IN_VALID = 1'b0;
         #1;
         if (cyc >= 5 && cyc <= 9) begin
            checks++;
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
               errors++;
               $display("FAIL stall_cycle%0d: in_ready=%b out_valid=%b want 0 1", cyc, IN_READY, OUT_VALID);
            end
         end
         acc = IN_VALID && IN_READY;
         if (OUT_VALID && OUT_READY) begin
            checks++;
            if (rcv >= 6 || P !== 48'(101 * (rcv + 1))) begin
               errors++;
               $display("FAIL bp_result[%0d]: got %0d want %0d", rcv, P, 101 * (rcv + 1));
            end
            rcv++;
         end
         tick();
         if (acc) idx++;
      end
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      checks++;
      if (rcv !== 6 || idx !== 6) begin
         errors++; $display("FAIL bp_count: received %0d sent %0d want 6 6", rcv, idx);
      end
   endtask

   task automatic test_reset_midflight();
      for (int k = 0; k < 3; k++) begin
         drive(18'sd1, 18'sd1, 18'sd0, 48'sd50, 4'b0000);
         tick();
      end
      IN_VALID = 1'b0;
      RSTN = 1'b0;
      #2;
      checks++;
      if (OUT_VALID !== 1'b0 || P !== 48'sd0) begin
         errors++; $display("FAIL midflight_reset: out_valid=%b p=%0d want 0 0", OUT_VALID, P);
      end
      @(negedge CLK);
      RSTN = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL midflight_ghost%0d: out_valid=%b want 0", k, OUT_VALID);
         end
      end
      send(18'sd0, 18'sd0, 18'sd0, 48'sd7, 4'b0000);
      tick(); tick(); tick();
      checks++;
      if (OUT_VALID !== 1'b1 || P !== 48'sd7) begin
         errors++; $display("FAIL midflight_recover: out_valid=%b p=%0d want 1 7", OUT_VALID, P);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_latency();
      test_acc_stream();
      test_saturation();
      test_back_to_back();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
